// File: rtl/dump_sustain_seq_if.sv
// -----------------------------------------------------------------------------
// dump_sustain_seq_if
// Bundles the signals between the dump/sustain phase sequencer and the logic
// around it: the programmed phase profile and run request going in, and the
// phase enables and run status coming out.
//
//   master : top-level state machine side (drives profile and requests)
//   slave  : dump_sustain_seq side
//
// Signals (master -> slave):
//   state_start  run request level, rising edge starts a run
//   abort        synchronous abort level
//   dump_len     DUMP phase length in clk_5k ticks (0 skips the phase)
//   sustain_len  SUSTAIN phase length in clk_5k ticks (0 acts as 1)
//   gap_len      GAP phase length in clk_5k ticks (0 skips the phase)
//   rep_num      repetitions per run (0 gives an immediate done)
// Signals (slave -> master):
//   dump_on, sustain_on  phase enables for the dump and sustain timers
//   start                one-tick pulse at the start of every SUSTAIN phase
//   busy, done           run status; done pulses once on normal completion
//   rep_cnt              completed repetitions of the current or last run
//   fsm_state            sequencer state, for debug and assertion binding
//
// There is no valid/ready handshake on this bus: the profile is sampled in the
// same tick as the state_start rising edge, and all outputs are plain levels
// or single-tick pulses that the consumer must sample every clk_5k edge.
// -----------------------------------------------------------------------------
interface dump_sustain_seq_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic             state_start;
  logic             abort;
  logic [CNT_W-1:0] dump_len;
  logic [CNT_W-1:0] sustain_len;
  logic [CNT_W-1:0] gap_len;
  logic [REP_W-1:0] rep_num;

  logic             dump_on;
  logic             sustain_on;
  logic             start;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] rep_cnt;
  logic [2:0]       fsm_state;

  modport master (
    output state_start, abort, dump_len, sustain_len, gap_len, rep_num,
    input  dump_on, sustain_on, start, busy, done, rep_cnt, fsm_state
  );

  modport slave (
    input  state_start, abort, dump_len, sustain_len, gap_len, rep_num,
    output dump_on, sustain_on, start, busy, done, rep_cnt, fsm_state
  );
endinterface

// File: rtl/dump_sustain_seq.sv
// -----------------------------------------------------------------------------
// dump_sustain_seq
// Phase sequencer for the NMR dump/sustain timing chain (clk_5k domain).
// A rising edge of state_start latches the phase profile and runs rep_num
// repetitions of DUMP -> SUSTAIN -> GAP, ending with a one-tick done pulse.
//
// Ports:
//   clk_5k  5 kHz timer clock, all logic on its rising edge
//   rst_n   asynchronous active-low reset
//   bus     dump_sustain_seq_if.slave (profile in, phase enables/status out)
//
// All outputs are registered. A single down-counter times every phase: it is
// loaded with (length - 1) on phase entry and the phase ends on the tick where
// it reads zero, so back-to-back phases hand over on the same edge.
// -----------------------------------------------------------------------------
module dump_sustain_seq #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic               clk_5k,
  input  logic               rst_n,
  dump_sustain_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUMP    = 3'd1,
    S_SUSTAIN = 3'd2,
    S_GAP     = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state;
  logic             st_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dump_q;
  logic [CNT_W-1:0] sus_q;
  logic [CNT_W-1:0] gap_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             dump_on_q;
  logic             sus_on_q;
  logic             start_q;
  logic             busy_q;
  logic             done_q;

  logic             rise;
  logic [REP_W-1:0] rep_next;

  assign rise     = bus.state_start & ~st_d;
  assign rep_next = rep_cnt_q + REP_ONE;

  // Counter preload for a phase of 'len' ticks. A zero length only reaches
  // here for SUSTAIN, where it must still last one tick.
  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_ONE;
  endfunction

  always_ff @(posedge clk_5k or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      st_d      <= 1'b0;
      cnt       <= '0;
      dump_q    <= '0;
      sus_q     <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      rep_cnt_q <= '0;
      dump_on_q <= 1'b0;
      sus_on_q  <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // st_d tracks the request continuously, so a level held through a run
      // never looks like a new edge once the sequencer returns to IDLE.
      st_d    <= bus.state_start;
      start_q <= 1'b0;
      done_q  <= 1'b0;

      if (state != S_IDLE && bus.abort) begin
        state     <= S_IDLE;
        dump_on_q <= 1'b0;
        sus_on_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise && !bus.abort) begin
              dump_q    <= bus.dump_len;
              sus_q     <= bus.sustain_len;
              gap_q     <= bus.gap_len;
              rep_q     <= bus.rep_num;
              rep_cnt_q <= '0;
              busy_q    <= 1'b1;
              if (bus.rep_num == '0) begin
                state  <= S_FIN;
                done_q <= 1'b1;
              end else if (bus.dump_len != '0) begin
                state     <= S_DUMP;
                dump_on_q <= 1'b1;
                cnt       <= load_of(bus.dump_len);
              end else begin
                state    <= S_SUSTAIN;
                sus_on_q <= 1'b1;
                start_q  <= 1'b1;
                cnt      <= load_of(bus.sustain_len);
              end
            end
          end

          S_DUMP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              state     <= S_SUSTAIN;
              dump_on_q <= 1'b0;
              sus_on_q  <= 1'b1;
              start_q   <= 1'b1;
              cnt       <= load_of(sus_q);
            end
          end

          S_SUSTAIN: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              sus_on_q <= 1'b0;
              if (rep_cnt_q != rep_q) rep_cnt_q <= rep_next;
              if (rep_next == rep_q) begin
                state  <= S_FIN;
                done_q <= 1'b1;
              end else if (gap_q != '0) begin
                state <= S_GAP;
                cnt   <= load_of(gap_q);
              end else if (dump_q != '0) begin
                state     <= S_DUMP;
                dump_on_q <= 1'b1;
                cnt       <= load_of(dump_q);
              end else begin
                // Stay in SUSTAIN for the next repetition with a fresh strobe.
                sus_on_q <= 1'b1;
                start_q  <= 1'b1;
                cnt      <= load_of(sus_q);
              end
            end
          end

          S_GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else if (dump_q != '0) begin
              state     <= S_DUMP;
              dump_on_q <= 1'b1;
              cnt       <= load_of(dump_q);
            end else begin
              state    <= S_SUSTAIN;
              sus_on_q <= 1'b1;
              start_q  <= 1'b1;
              cnt      <= load_of(sus_q);
            end
          end

          S_FIN: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end

          default: begin
            state     <= S_IDLE;
            dump_on_q <= 1'b0;
            sus_on_q  <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dump_on    = dump_on_q;
  assign bus.sustain_on = sus_on_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rep_cnt    = rep_cnt_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_dump_sustain_seq.sv
// -----------------------------------------------------------------------------
// tb_dump_sustain_seq
// Directed bench for dump_sustain_seq: an exact per-tick waveform for the
// reset-release run, a table of profiles checked by phase tick counts, and
// hand-written sequences for abort, mid-run input changes and reset mid-run.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dump_sustain_seq;

  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  // ---------------- clock / reset ----------------
  logic clk_5k = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_5k = ~clk_5k;

  dump_sustain_seq_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  dump_sustain_seq #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk_5k (clk_5k),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit perturb_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int dump_len;
    int sustain_len;
    int gap_len;
    int rep_num;
    int exp_busy;
    int exp_dump;
    int exp_sus;
    int exp_start;
    int exp_done;
    int exp_rep;
  } vec_t;

  typedef struct {
    int n_busy;
    int n_dump;
    int n_sus;
    int n_start;
    int n_done;
    bit timed_out;
  } run_t;

  // ---------------- driver tasks ----------------
  task automatic set_profile(input int d, input int s, input int g, input int r);
    bus.dump_len    = CNT_W'(d);
    bus.sustain_len = CNT_W'(s);
    bus.gap_len     = CNT_W'(g);
    bus.rep_num     = REP_W'(r);
  endtask

  // Drop state_start for one tick, then raise it for the next edge.
  task automatic request_run();
    bus.state_start = 1'b0;
    @(negedge clk_5k);
    bus.state_start = 1'b1;
  endtask

  // Counts output activity tick by tick until busy has been seen and drops.
  task automatic watch_run(input int budget, output run_t r);
    r = '{default: 0};
    r.timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_5k);
      if (perturb_en) begin
        if (i == 2) bus.state_start = 1'b0;
        if (i == 3) begin
          bus.state_start = 1'b1;
          bus.dump_len    = CNT_W'(7);
        end
      end
      if (bus.busy)       r.n_busy++;
      if (bus.dump_on)    r.n_dump++;
      if (bus.sustain_on) r.n_sus++;
      if (bus.start)      r.n_start++;
      if (bus.done)       r.n_done++;
      if (!bus.busy && r.n_busy > 0) begin
        r.timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input run_t r, input vec_t v);
    check({tag, " timeout"},    int'(r.timed_out), 0);
    check({tag, " busy_ticks"}, r.n_busy,  v.exp_busy);
    check({tag, " dump_ticks"}, r.n_dump,  v.exp_dump);
    check({tag, " sus_ticks"},  r.n_sus,   v.exp_sus);
    check({tag, " starts"},     r.n_start, v.exp_start);
    check({tag, " dones"},      r.n_done,  v.exp_done);
    check({tag, " rep_cnt"},    int'(bus.rep_cnt), v.exp_rep);
  endtask

  task automatic check_quiet(input string tag, input int rep);
    check({tag, " dump_on"},    int'(bus.dump_on),    0);
    check({tag, " sustain_on"}, int'(bus.sustain_on), 0);
    check({tag, " start"},      int'(bus.start),      0);
    check({tag, " busy"},       int'(bus.busy),       0);
    check({tag, " done"},       int'(bus.done),       0);
    check({tag, " rep_cnt"},    int'(bus.rep_cnt),    rep);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  run_t r;

  initial begin
    // busy = rep*(dump + max(sus,1)) + (rep-1)*gap + 1 FIN tick
    vecs[0] = '{0, 0, 0, 3,  4,  0,  3, 3, 1, 3};
    vecs[1] = '{2, 2, 2, 0,  1,  0,  0, 0, 1, 0};
    vecs[2] = '{1, 1, 1, 1,  3,  1,  1, 1, 1, 1};
    vecs[3] = '{2, 3, 0, 2, 11,  4,  6, 2, 1, 2};
    vecs[4] = '{0, 5, 3, 2, 14,  0, 10, 2, 1, 2};
    vecs[5] = '{4, 0, 1, 3, 18, 12,  3, 3, 1, 3};

    bus.abort       = 1'b0;
    bus.state_start = 1'b1;
    set_profile(3, 4, 2, 2);

    // --- reset state, then release with state_start already high ---
    repeat (2) @(negedge clk_5k);
    check_quiet("reset", 0);
    check("reset fsm_state", int'(bus.fsm_state), 0);
    rst_n = 1'b1;

    for (int c = 1; c <= 18; c++) begin
      automatic int e_d  = ((c >= 1 && c <= 3) || (c >= 10 && c <= 12)) ? 1 : 0;
      automatic int e_s  = ((c >= 4 && c <= 7) || (c >= 13 && c <= 16)) ? 1 : 0;
      automatic int e_st = (c == 4 || c == 13) ? 1 : 0;
      automatic int e_b  = (c <= 17) ? 1 : 0;
      automatic int e_dn = (c == 17) ? 1 : 0;
      automatic int e_rc = (c < 8) ? 0 : ((c < 17) ? 1 : 2);
      @(negedge clk_5k);
      check($sformatf("t1 c%0d dump_on", c),    int'(bus.dump_on),    e_d);
      check($sformatf("t1 c%0d sustain_on", c), int'(bus.sustain_on), e_s);
      check($sformatf("t1 c%0d start", c),      int'(bus.start),      e_st);
      check($sformatf("t1 c%0d busy", c),       int'(bus.busy),       e_b);
      check($sformatf("t1 c%0d done", c),       int'(bus.done),       e_dn);
      check($sformatf("t1 c%0d rep_cnt", c),    int'(bus.rep_cnt),    e_rc);
    end

    // --- profile table ---
    for (int k = 0; k < 6; k++) begin
      set_profile(vecs[k].dump_len, vecs[k].sustain_len, vecs[k].gap_len, vecs[k].rep_num);
      request_run();
      watch_run(100, r);
      check_run($sformatf("vec%0d", k), r, vecs[k]);
      bus.state_start = 1'b0;
      @(negedge clk_5k);
    end

    // --- request toggled and dump_len changed mid-sustain ---
    set_profile(2, 3, 1, 2);
    request_run();
    perturb_en = 1'b1;
    watch_run(100, r);
    perturb_en = 1'b0;
    check_run("midrun", r, '{2, 3, 1, 2, 12, 4, 6, 2, 1, 2});
    begin
      automatic int extra = 0;
      repeat (5) begin
        @(negedge clk_5k);
        if (bus.busy) extra++;
      end
      check("midrun no_second_run", extra, 0);
    end
    bus.state_start = 1'b0;
    @(negedge clk_5k);

    // --- abort in tick 2 of the second DUMP of a 3-rep run ---
    set_profile(3, 2, 1, 3);
    request_run();
    for (int c = 1; c <= 8; c++) @(negedge clk_5k);
    check("abort pre dump_on", int'(bus.dump_on), 1);
    bus.abort = 1'b1;
    @(negedge clk_5k);
    bus.abort = 1'b0;
    check_quiet("abort", 1);
    check("abort fsm_state", int'(bus.fsm_state), 0);
    begin
      automatic int late = 0;
      repeat (3) begin
        @(negedge clk_5k);
        if (bus.done || bus.busy) late++;
      end
      check("abort no_done", late, 0);
    end
    request_run();
    @(negedge clk_5k);
    check("restart busy",    int'(bus.busy),    1);
    check("restart rep_cnt", int'(bus.rep_cnt), 0);
    check("restart dump_on", int'(bus.dump_on), 1);
    watch_run(100, r);
    r.n_busy++;  // the first run tick was sampled above
    r.n_dump++;
    check_run("restart", r, '{3, 2, 1, 3, 18, 9, 6, 3, 1, 3});
    bus.state_start = 1'b0;
    @(negedge clk_5k);

    // --- abort in IDLE masks a coincident rise ---
    bus.state_start = 1'b1;
    bus.abort       = 1'b1;
    @(negedge clk_5k);
    bus.abort = 1'b0;
    check("idle_abort busy", int'(bus.busy), 0);
    @(negedge clk_5k);
    check("idle_abort held busy", int'(bus.busy), 0);
    bus.state_start = 1'b0;
    @(negedge clk_5k);

    // --- async reset mid-sustain with state_start held high ---
    set_profile(2, 4, 1, 1);
    request_run();
    for (int c = 1; c <= 4; c++) @(negedge clk_5k);
    check("rst pre sustain_on", int'(bus.sustain_on), 1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst async", 0);
    @(negedge clk_5k);
    rst_n = 1'b1;
    watch_run(100, r);
    check_run("rst restart", r, '{2, 4, 1, 1, 7, 2, 4, 1, 1, 1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
